// File: rtl/l2spm_arbiter.sv
// Round-robin arbiter of NumReq requesters onto one L2 SPM port, one transaction in flight; optional watchdog under L2SPM_ARB_TIMEOUT_EN.
// Latency accept->rsp is 3 cycles minimum; requesters wait while the port is busy.
module l2spm_arbiter #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter logic [63:0] BaseAddr      = 64'h1C00_0000,
  parameter logic [63:0] Length        = 64'h80000,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0]                   req_we_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
  output logic [NumReq-1:0]                   rsp_valid_o,
  output logic [DataWidth-1:0]                rsp_rdata_o,
  output logic                                rsp_err_o,
  output logic                                mem_req_o,
  input  logic                                mem_gnt_i,
  output logic [AddrWidth-1:0]                mem_addr_o,
  output logic                                mem_we_o,
  output logic [DataWidth-1:0]                mem_wdata_o,
  input  logic                                mem_rvalid_i,
  input  logic [DataWidth-1:0]                mem_rdata_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  // One extra bit so BaseAddr+Length cannot wrap at full address width.
  localparam logic [AddrWidth:0] RangeLo = (AddrWidth+1)'(BaseAddr);
  localparam logic [AddrWidth:0] RangeHi = RangeLo + (AddrWidth+1)'(Length);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RSP, ERR} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, last_grant_q, winner;
  logic                 req_any, accept, in_range, timeout;
  logic [AddrWidth-1:0] addr_q;
  logic                 we_q;
  logic [DataWidth-1:0] wdata_q, rdata_q;

  always_comb begin
    int unsigned cand;
    winner  = last_grant_q;
    req_any = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = (32'(last_grant_q) + i) % NumReq;
      if (!req_any && req_valid_i[IdxW'(cand)]) begin
        req_any = 1'b1;
        winner  = IdxW'(cand);
      end
    end
  end

  assign accept   = (state_q == IDLE) && req_any;
  assign in_range = ({1'b0, addr_q} >= RangeLo) && ({1'b0, addr_q} < RangeHi);

`ifdef L2SPM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TimeoutCycles + 1) > 8) ? $clog2(TimeoutCycles + 1) : 8;
  logic [CntW-1:0] tmo_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (accept) begin
      tmo_cnt_q <= '0;
    end else if (state_q == REQ || state_q == WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == REQ || state_q == WAIT) && (tmo_cnt_q == CntW'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  // The range check runs in the first REQ cycle on the latched address; out-of-range never raises mem_req_o.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_any) state_d = REQ;
      REQ: begin
        if (!in_range)      state_d = ERR;
        else if (mem_gnt_i) state_d = WAIT;
        else if (timeout)   state_d = ERR;
      end
      WAIT: begin
        if (mem_rvalid_i)   state_d = RSP;
        else if (timeout)   state_d = ERR;
      end
      RSP:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= IdxW'(NumReq - 1);
      idx_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q        <= winner;
        last_grant_q <= winner;
        addr_q       <= req_addr_i[winner];
        we_q         <= req_we_i[winner];
        wdata_q      <= req_wdata_i[winner];
      end
      if (state_q == WAIT && mem_rvalid_i) rdata_q <= mem_rdata_i;
    end
  end

  // Ready is combinational; gating with reset keeps every output low while reset is held.
  assign req_ready_o = (accept && rst_ni) ? (NumReq'(1) << winner) : '0;
  assign mem_req_o   = (state_q == REQ) && in_range;
  assign mem_addr_o  = mem_req_o ? (addr_q - AddrWidth'(BaseAddr)) : '0;
  assign mem_we_o    = mem_req_o && we_q;
  assign mem_wdata_o = mem_req_o ? wdata_q : '0;
  assign rsp_valid_o = (state_q == RSP || state_q == ERR) ? (NumReq'(1) << idx_q) : '0;
  assign rsp_rdata_o = (state_q == RSP) ? rdata_q : '0;
  assign rsp_err_o   = (state_q == ERR);

endmodule

// File: tb/tb_l2spm_arbiter.sv
// Directed bench for l2spm_arbiter: latency, range errors, round-robin order, reset mid-transaction, optional watchdog.
module tb_l2spm_arbiter;
  localparam int N = 4, AW = 64, DW = 64;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [N-1:0]          req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
  logic [N-1:0][AW-1:0]  req_addr_i;
  logic [N-1:0][DW-1:0]  req_wdata_i;
  logic [DW-1:0]         rsp_rdata_o, mem_wdata_o, mem_rdata_i;
  logic                  rsp_err_o, mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [AW-1:0]         mem_addr_o;

  int n_chk = 0, n_fail = 0;
  logic auto_mem = 1'b0, gnt_prev = 1'b0;

  always #5 clk_i = ~clk_i;

  l2spm_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance into the next cycle; the memory model grants immediately and returns rvalid one cycle later.
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (auto_mem) begin
      mem_rvalid_i = gnt_prev;
      gnt_prev     = mem_req_o;
      mem_gnt_i    = mem_req_o;
    end
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    gnt_prev = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(req_ready_o), 64'h0);
    check({tag, "_rspv"},  64'(rsp_valid_o), 64'h0);
    check({tag, "_rdata"}, rsp_rdata_o, 64'h0);
    check({tag, "_err"},   64'(rsp_err_o), 64'h0);
    check({tag, "_mreq"},  64'(mem_req_o), 64'h0);
    check({tag, "_maddr"}, mem_addr_o, 64'h0);
    check({tag, "_mwe"},   64'(mem_we_o), 64'h0);
    check({tag, "_mwd"},   mem_wdata_o, 64'h0);
  endtask

  // Present one request for one cycle and check that it is accepted then.
  task automatic issue(input int r, input logic [63:0] addr, input logic we, input logic [63:0] wd);
    tick();
    req_valid_i = '0;
    req_valid_i[r] = 1'b1;
    req_addr_i[r] = addr; req_we_i[r] = we; req_wdata_i[r] = wd;
    sample();
    check($sformatf("accept_r%0d", r), 64'(req_ready_o), 64'(4'b0001 << r));
  endtask

  initial begin
    int order[5];
    int k;
    int n;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    rst_ni = 1'b0;
    req_valid_i = '0; req_addr_i = '0; req_we_i = '0; req_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'hA5;
    sample();
    check_idle_outputs("reset");
    do_reset();

    // Minimum-latency read.
    auto_mem = 1'b1;
    issue(0, 64'h1C00_0010, 1'b0, 64'h0);
    tick(); req_valid_i = '0; sample();
    check("rd_t1_mreq", 64'(mem_req_o), 64'h1);
    check("rd_t1_maddr", mem_addr_o, 64'h10);
    check("rd_t1_mwe", 64'(mem_we_o), 64'h0);
    check("rd_t1_rspv", 64'(rsp_valid_o), 64'h0);
    tick(); sample();
    check("rd_t2_mreq", 64'(mem_req_o), 64'h0);
    check("rd_t2_rspv", 64'(rsp_valid_o), 64'h0);
    tick(); sample();
    check("rd_t3_rspv", 64'(rsp_valid_o), 64'h1);
    check("rd_t3_rdata", rsp_rdata_o, 64'hA5);
    check("rd_t3_err", 64'(rsp_err_o), 64'h0);
    tick(); sample();
    check("rd_t4_rspv", 64'(rsp_valid_o), 64'h0);
    check("rd_t4_rdata", rsp_rdata_o, 64'h0);

    // One past the end of the SPM.
    issue(2, 64'h1C08_0000, 1'b0, 64'h0);
    tick(); req_valid_i = '0; sample();
    check("oor_t1_mreq", 64'(mem_req_o), 64'h0);
    check("oor_t1_rspv", 64'(rsp_valid_o), 64'h0);
    tick(); sample();
    check("oor_t2_rspv", 64'(rsp_valid_o), 64'h4);
    check("oor_t2_err", 64'(rsp_err_o), 64'h1);
    check("oor_t2_rdata", rsp_rdata_o, 64'h0);
    tick(); sample();
    check("oor_t3_rspv", 64'(rsp_valid_o), 64'h0);
    check("oor_t3_err", 64'(rsp_err_o), 64'h0);

    // Last in-range doubleword, write; response returns the captured read data.
    mem_rdata_i = 64'h5A;
    issue(1, 64'h1C07_FFF8, 1'b1, 64'hDEAD_BEEF);
    tick(); req_valid_i = '0; sample();
    check("wr_t1_mreq", 64'(mem_req_o), 64'h1);
    check("wr_t1_maddr", mem_addr_o, 64'h7FFF8);
    check("wr_t1_mwe", 64'(mem_we_o), 64'h1);
    check("wr_t1_mwd", mem_wdata_o, 64'hDEAD_BEEF);
    tick(); sample();
    tick(); sample();
    check("wr_t3_rspv", 64'(rsp_valid_o), 64'h2);
    check("wr_t3_rdata", rsp_rdata_o, 64'h5A);
    check("wr_t3_err", 64'(rsp_err_o), 64'h0);

    // Just below the base.
    tick(); sample();
    issue(3, 64'h1BFF_FFF8, 1'b0, 64'h0);
    tick(); req_valid_i = '0; sample();
    check("low_t1_mreq", 64'(mem_req_o), 64'h0);
    tick(); sample();
    check("low_t2_rspv", 64'(rsp_valid_o), 64'h8);
    check("low_t2_err", 64'(rsp_err_o), 64'h1);

    // All requesters valid from reset: round-robin order.
    tick();
    rst_ni = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr_i[i] = 64'h1C00_0000 + 64'(i * 8);
      req_we_i[i] = 1'b0;
    end
    req_valid_i = 4'b1111;
    sample();
    check("rr_reset_ready", 64'(req_ready_o), 64'h0);
    do_reset();
    k = 0;
    for (int c = 0; c < 60 && k < 5; c++) begin
      sample();
      if (req_ready_o != '0) begin
        check("rr_onehot", 64'($countones(req_ready_o)), 64'h1);
        for (int b = 0; b < N; b++) if (req_ready_o[b]) order[k] = b;
        k++;
      end
      if (k < 5) tick();
    end
    check("rr_count", 64'(k), 64'h5);
    for (int i = 0; i < 5; i++)
      if (i < k) check($sformatf("rr_order%0d", i), 64'(order[i]), 64'(exp_order[i]));
    tick(); req_valid_i = '0;

    // Reset during WAIT drops the transaction.
    auto_mem = 1'b0;
    do_reset();
    issue(3, 64'h1C00_0100, 1'b0, 64'h0);
    tick(); req_valid_i = '0; mem_gnt_i = 1'b1; sample();
    check("rst_t1_mreq", 64'(mem_req_o), 64'h1);
    tick(); mem_gnt_i = 1'b0; sample();
    check("rst_t2_mreq", 64'(mem_req_o), 64'h0);
    tick(); rst_ni = 1'b0; mem_rvalid_i = 1'b1; sample();
    check_idle_outputs("rst_mid");
    tick(); rst_ni = 1'b1; sample();
    check("rst_rv_ignored", 64'(rsp_valid_o), 64'h0);
    tick(); mem_rvalid_i = 1'b0; sample();
    check("rst_no_rsp", 64'(rsp_valid_o), 64'h0);
    tick(); req_valid_i = 4'b1001; sample();
    check("rst_next_r0", 64'(req_ready_o), 64'h1);
    tick(); req_valid_i = '0;

`ifdef L2SPM_ARB_TIMEOUT_EN
    // Watchdog: grant never arrives.
    do_reset();
    issue(0, 64'h1C00_0020, 1'b0, 64'h0);
    req_valid_i = '0;
    n = 0;
    for (int c = 0; c < 400; c++) begin
      tick(); sample(); n++;
      if (rsp_valid_o != '0) break;
    end
    check("tmo_cycles", 64'(n), 64'd256);
    check("tmo_err", 64'(rsp_err_o), 64'h1);
    tick(); mem_rvalid_i = 1'b1; sample();
    check("tmo_late_rv", 64'(rsp_valid_o), 64'h0);
    tick(); mem_rvalid_i = 1'b0; sample();
    check("tmo_late_rv2", 64'(rsp_valid_o), 64'h0);
`else
    n = 0;
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/l2spm_arbiter.md
L2SPM_ARBITER -- requirements
Module: l2spm_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, giving the number of requesters.
REQ-002 SHALL have parameter AddrWidth, default 64, giving the address width.
REQ-003 SHALL have parameter DataWidth, default 64, giving the data width.
REQ-004 SHALL have parameter BaseAddr, default 64'h1C00_0000, giving the L2 SPM base address.
REQ-005 SHALL have parameter Length, default 64'h80000, giving the L2 SPM size in bytes.
REQ-006 SHALL have parameter TimeoutCycles, default 255, giving the watchdog limit (used only with the Configuration macro defined).
REQ-007 SHALL have one clock and an asynchronous active-low reset; ports in order:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_valid_i  in  NumReq  per-requester request valid
- req_ready_o  out  NumReq  per-requester accept pulse
- req_addr_i  in  NumReq x AddrWidth  request byte address
- req_we_i  in  NumReq  1 = write
- req_wdata_i  in  NumReq x DataWidth  write data
- rsp_valid_o  out  NumReq  per-requester response pulse
- rsp_rdata_o  out  DataWidth  shared response data
- rsp_err_o  out  1  response error flag
- mem_req_o  out  1  SPM request
- mem_gnt_i  in  1  SPM grant
- mem_addr_o  out  AddrWidth  SPM offset (addr - BaseAddr)
- mem_we_o  out  1  SPM write enable
- mem_wdata_o  out  DataWidth  SPM write data
- mem_rvalid_i  in  1  SPM response valid
- mem_rdata_i  in  DataWidth  SPM read data

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT, RSP, ERR; one transaction outstanding at a time.
REQ-009 In IDLE with any req_valid_i set, SHALL pick a winner round-robin starting at (last_grant+1) mod NumReq, pulse req_ready_o[winner] for that cycle, latch idx/addr/we/wdata, and update last_grant.
REQ-010 Range check on latched addr: BaseAddr <= addr < BaseAddr+Length, full-width unsigned; in range -> REQ, else -> ERR.
REQ-011 REQ: mem_req_o=1 with latched fields held stable until mem_gnt_i; grant cycle -> WAIT (mem_req_o deasserts the following cycle).
REQ-012 WAIT: on mem_rvalid_i, SHALL capture mem_rdata_i -> RSP; mem_rvalid_i in same cycle as gnt is not accepted (rvalid is sampled only in WAIT).
REQ-013 RSP: rsp_valid_o[idx]=1 for exactly one cycle, rsp_rdata_o=captured data (writes return captured rdata unchanged), rsp_err_o=0 -> IDLE.
REQ-014 ERR: rsp_valid_o[idx]=1 for one cycle, rsp_err_o=1, rsp_rdata_o=0, no SPM access -> IDLE.
REQ-015 Minimum latency, in-range request, gnt immediate, rvalid one cycle later: accept cycle T, mem_req_o at T+1, response at T+3.
REQ-016 rsp_rdata_o and rsp_err_o SHALL be 0 whenever no rsp_valid_o bit is set; at most one bit of req_ready_o and rsp_valid_o set per cycle.
REQ-017 mem_rvalid_i in IDLE, REQ, RSP, or ERR SHALL be ignored.

Reset
REQ-018 On rst_ni low, asynchronously: state=IDLE, last_grant=NumReq-1 (requester 0 wins first), latched fields=0, timeout counter=0, all outputs 0.
REQ-019 Reset mid-transaction SHALL drop it with no response; requester re-issues.

Configuration
REQ-020 Macro L2SPM_ARB_TIMEOUT_EN defined: an 8-bit-or-wider counter clears on entry to REQ and increments each cycle in REQ or WAIT; reaching TimeoutCycles -> ERR, with mem_req_o dropped and a late mem_rvalid_i ignored per REQ-017.
REQ-021 Macro undefined: no counter logic; REQ and WAIT wait indefinitely.

Verification
REQ-022 Req 0 read addr 0x1C00_0010, gnt immediate, rvalid next cycle with data 0xA5 -> mem_addr_o=0x10, rsp_valid_o[0] at T+3, rdata=0xA5, err=0.
REQ-023 Requesters 0-3 all valid continuously from reset -> accept order 0,1,2,3,0.
REQ-024 Req 2 addr 0x1C08_0000 (one past end) -> no mem_req_o, rsp_valid_o[2] with err=1 two cycles after accept.
REQ-025 Macro defined, TimeoutCycles=255, mem_gnt_i held 0 -> err response after 255 cycles in REQ; subsequent rvalid ignored.
REQ-026 rst_ni low during WAIT, then release -> all outputs 0, no rsp_valid_o, next accept goes to requester 0.
